// File: rtl/fir_sym_mc.sv
// fir_sym_mc: folded symmetric/antisymmetric FIR, FW taps (odd), CH
// time-interleaved channels with independent delay lines.
//
// Five-stage pipeline, with valid and channel tag carried alongside:
//   1: delay-line shift
//   2: pre-add/pre-subtract; the coefficient bank is snapshotted here
//   3: products
//   4: full-precision sum
//   5: round half up, saturate and register the output
//
// Ports:
//   Clk, Rstn              clock, asynchronous active-low reset
//   Clear                  synchronous flush of lines, pipe valids and SatFlag
//   DataIn/DataInCh/DataInVld  sample input with channel tag
//   Antisym                0 = symmetric (pre-add), 1 = antisymmetric
//   CoeffIn/CoeffLd        coefficient bank load (c0 in LSBs, centre tap last)
//   DataOut/DataOutCh/DataOutVld  filtered sample, latency 5 cycles
//   SatFlag                sticky saturation indicator
module fir_sym_mc #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int FW = 7,
  parameter int CH = 2,
  parameter int SL = 7,
  localparam int FN  = (FW + 1) / 2,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW  = DW + 1 + CW + $clog2(FN)
) (
  input  logic                 Clk,
  input  logic                 Rstn,
  input  logic                 Clear,
  input  logic signed [DW-1:0] DataIn,
  input  logic [CHW-1:0]       DataInCh,
  input  logic                 DataInVld,
  input  logic                 Antisym,
  input  logic [FN*CW-1:0]     CoeffIn,
  input  logic                 CoeffLd,
  output logic signed [DW-1:0] DataOut,
  output logic [CHW-1:0]       DataOutCh,
  output logic                 DataOutVld,
  output logic                 SatFlag
);

  localparam int PW = DW + 1;   // pre-adder width
  localparam int MW = PW + CW;  // product width
  localparam logic [CHW:0] CH_L = (CHW + 1)'(CH);
  localparam logic signed [DW-1:0] OMAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] OMIN = {1'b1, {(DW - 1){1'b0}}};
  localparam logic signed [AW:0]   MAXV = (AW + 1)'(OMAX);
  localparam logic signed [AW:0]   MINV = (AW + 1)'(OMIN);
  // Half an output LSB, added before the arithmetic shift (round half up).
  localparam logic signed [AW:0]   RND  = (SL > 0) ?
      ((AW + 1)'(1'b1) << ((SL > 0) ? (SL - 1) : 0)) : '0;

  // Coefficient bank
  logic signed [CW-1:0] bank_r [FN];

  // Stage 1
  logic signed [DW-1:0] line_r [CH][FW];
  logic                 v1_r;
  logic                 anti1_r;
  logic [CHW-1:0]       ch1_r;
  logic                 in_ok_s;

  // Stage 2
  logic signed [DW-1:0] x_s   [FW];
  logic signed [PW-1:0] pa_s  [FN];
  logic signed [PW-1:0] pa2_r [FN];
  logic signed [CW-1:0] cf2_r [FN];
  logic                 v2_r;
  logic [CHW-1:0]       ch2_r;

  // Stage 3
  logic signed [MW-1:0] pr3_r [FN];
  logic                 v3_r;
  logic [CHW-1:0]       ch3_r;

  // Stage 4
  logic signed [AW-1:0] sum_s;
  logic signed [AW-1:0] sum4_r;
  logic                 v4_r;
  logic [CHW-1:0]       ch4_r;

  // Stage 5
  logic signed [AW:0]   rnd_s;
  logic signed [AW:0]   rsh_s;
  logic signed [DW-1:0] out_s;
  logic                 clip_s;

  // Out-of-range channels are dropped at the door.
  assign in_ok_s = DataInVld && ({1'b0, DataInCh} < CH_L);

  // Coefficient bank: loaded on CoeffLd, untouched by Clear.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < FN; i++) bank_r[i] <= '0;
    end else if (CoeffLd) begin
      for (int i = 0; i < FN; i++) bank_r[i] <= CoeffIn[i*CW +: CW];
    end
  end

  // Stage 1: shift only the addressed channel's delay line.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < FW; k++) line_r[c][k] <= '0;
      v1_r    <= 1'b0;
      anti1_r <= 1'b0;
      ch1_r   <= '0;
    end else if (Clear) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < FW; k++) line_r[c][k] <= '0;
      v1_r    <= 1'b0;
      anti1_r <= 1'b0;
      ch1_r   <= '0;
    end else begin
      v1_r <= in_ok_s;
      if (in_ok_s) begin
        ch1_r   <= DataInCh;
        anti1_r <= Antisym;
      end
      for (int c = 0; c < CH; c++) begin
        if (in_ok_s && (DataInCh == CHW'(c))) begin
          line_r[c][0] <= DataIn;
          for (int k = 1; k < FW; k++) line_r[c][k] <= line_r[c][k-1];
        end
      end
    end
  end

  // Stage 2 combinational: fold mirrored taps; centre tap zero when antisymmetric.
  always_comb begin
    for (int k = 0; k < FW; k++) x_s[k] = line_r[ch1_r][k];
    for (int i = 0; i < FN - 1; i++) begin
      if (anti1_r) begin
        pa_s[i] = PW'(x_s[i]) - PW'(x_s[FW-1-i]);
      end else begin
        pa_s[i] = PW'(x_s[i]) + PW'(x_s[FW-1-i]);
      end
    end
    if (anti1_r) begin
      pa_s[FN-1] = '0;
    end else begin
      pa_s[FN-1] = PW'(x_s[FN-1]);
    end
  end

  // Stage 2 register: pre-add results plus a snapshot of the bank, so a
  // later load cannot disturb samples already in flight.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < FN; i++) begin
        pa2_r[i] <= '0;
        cf2_r[i] <= '0;
      end
      v2_r  <= 1'b0;
      ch2_r <= '0;
    end else if (Clear) begin
      v2_r  <= 1'b0;
      ch2_r <= '0;
    end else begin
      for (int i = 0; i < FN; i++) begin
        pa2_r[i] <= pa_s[i];
        cf2_r[i] <= bank_r[i];
      end
      v2_r  <= v1_r;
      ch2_r <= ch1_r;
    end
  end

  // Stage 3: products.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < FN; i++) pr3_r[i] <= '0;
      v3_r  <= 1'b0;
      ch3_r <= '0;
    end else if (Clear) begin
      v3_r  <= 1'b0;
      ch3_r <= '0;
    end else begin
      for (int i = 0; i < FN; i++) pr3_r[i] <= MW'(pa2_r[i]) * MW'(cf2_r[i]);
      v3_r  <= v2_r;
      ch3_r <= ch2_r;
    end
  end

  // Stage 4 combinational: full-precision sum, AW is sized so it cannot wrap.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < FN; i++) sum_s = sum_s + AW'(pr3_r[i]);
  end

  // Stage 4 register.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      sum4_r <= '0;
      v4_r   <= 1'b0;
      ch4_r  <= '0;
    end else if (Clear) begin
      v4_r  <= 1'b0;
      ch4_r <= '0;
    end else begin
      sum4_r <= sum_s;
      v4_r   <= v3_r;
      ch4_r  <= ch3_r;
    end
  end

  // Stage 5 combinational: round half up, arithmetic shift, clamp.
  always_comb begin
    rnd_s = (AW + 1)'(sum4_r) + RND;
    rsh_s = rnd_s >>> SL;
    if (rsh_s > MAXV) begin
      out_s  = OMAX;
      clip_s = 1'b1;
    end else if (rsh_s < MINV) begin
      out_s  = OMIN;
      clip_s = 1'b1;
    end else begin
      out_s  = rsh_s[DW-1:0];
      clip_s = 1'b0;
    end
  end

  // Stage 5 register: outputs and sticky saturation flag.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      DataOut    <= '0;
      DataOutCh  <= '0;
      DataOutVld <= 1'b0;
      SatFlag    <= 1'b0;
    end else if (Clear) begin
      DataOutVld <= 1'b0;
      SatFlag    <= 1'b0;
    end else begin
      DataOutVld <= v4_r;
      if (v4_r) begin
        DataOut   <= out_s;
        DataOutCh <= ch4_r;
      end
      if (v4_r && clip_s) SatFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sym_mc.sv
// Scoreboard bench for fir_sym_mc. Two instances: d0 (SL=0) carries the
// impulse, interleave, saturation, clear, coefficient-switch and reset
// scenarios; d1 (SL=2) carries the rounding scenario. Expected outputs are
// hand-computed and queued with their due cycle (issue cycle + 5); monitors
// pop and compare whenever DataOutVld is seen.
module tb_fir_sym_mc;

  typedef struct packed {
    logic              ch;
    logic signed [9:0] d;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  logic              clr0, dch0, dv0, anti0, cld0;
  logic signed [9:0] din0;
  logic [39:0]       cin0;
  logic signed [9:0] dout0;
  logic              och0, ov0, sat0;

  logic              clr1, dch1, dv1, anti1, cld1;
  logic signed [9:0] din1;
  logic [39:0]       cin1;
  logic signed [9:0] dout1;
  logic              och1, ov1, sat1;

  fir_sym_mc #(.DW(10), .CW(10), .FW(7), .CH(2), .SL(0)) d0 (
    .Clk(clk), .Rstn(rstn), .Clear(clr0), .DataIn(din0), .DataInCh(dch0),
    .DataInVld(dv0), .Antisym(anti0), .CoeffIn(cin0), .CoeffLd(cld0),
    .DataOut(dout0), .DataOutCh(och0), .DataOutVld(ov0), .SatFlag(sat0));

  fir_sym_mc #(.DW(10), .CW(10), .FW(7), .CH(2), .SL(2)) d1 (
    .Clk(clk), .Rstn(rstn), .Clear(clr1), .DataIn(din1), .DataInCh(dch1),
    .DataInVld(dv1), .Antisym(anti1), .CoeffIn(cin1), .CoeffLd(cld1),
    .DataOut(dout1), .DataOutCh(och1), .DataOutVld(ov1), .SatFlag(sat1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for d0.
  always @(negedge clk) begin
    if (ov0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL d0_unexpected got=%0d ch=%0d cyc=%0d", dout0, och0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (dout0 !== e0.d || och0 !== e0.ch || cyc != e0.due) begin
          n_bad++;
          $display("FAIL d0_out got=%0d exp=%0d ch got=%0d exp=%0d cyc got=%0d exp=%0d",
                   dout0, e0.d, och0, e0.ch, cyc, e0.due);
        end
      end
    end
  end

  // Monitor for d1.
  always @(negedge clk) begin
    if (ov1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL d1_unexpected got=%0d ch=%0d cyc=%0d", dout1, och1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (dout1 !== e1.d || och1 !== e1.ch || cyc != e1.due) begin
          n_bad++;
          $display("FAIL d1_out got=%0d exp=%0d ch got=%0d exp=%0d cyc got=%0d exp=%0d",
                   dout1, e1.d, och1, e1.ch, cyc, e1.due);
        end
      end
    end
  end

  function automatic logic [39:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Drive one d0 sample this cycle; optionally queue its expected output.
  task automatic send0(input logic ch, input int x, input logic anti,
                       input logic push, input int e);
    dv0 = 1'b1; dch0 = ch; din0 = 10'(x); anti0 = anti;
    if (push) q0.push_back('{ch, 10'(e), cyc + 5});
    tick();
  endtask

  task automatic send1(input int x, input int e);
    dv1 = 1'b1; dch1 = 1'b0; din1 = 10'(x); anti1 = 1'b0;
    q1.push_back('{1'b0, 10'(e), cyc + 5});
    tick();
  endtask

  task automatic idle(input int n);
    dv0 = 1'b0; dv1 = 1'b0; din0 = '0; din1 = '0;
    repeat (n) tick();
  endtask

  int sym  [7] = '{1, 2, 3, 4, 3, 2, 1};
  int asy  [7] = '{1, 2, 3, 0, -3, -2, -1};
  int stp  [10] = '{1, 3, 6, 10, 1, 1, 1, 1, 1, 1};
  int rin  [6] = '{6, -6, 5, 7, -2, -5};
  int rout [6] = '{2, -1, 1, 2, 0, -1};

  initial begin
    rstn = 1'b0;
    clr0 = 1'b0; dch0 = 1'b0; dv0 = 1'b0; anti0 = 1'b0; cld0 = 1'b0; din0 = '0; cin0 = '0;
    clr1 = 1'b0; dch1 = 1'b0; dv1 = 1'b0; anti1 = 1'b0; cld1 = 1'b0; din1 = '0; cin1 = '0;
    repeat (3) tick();

    // Reset values.
    chk("rst_dout", int'(dout0), 0);
    chk("rst_vld", int'(ov0), 0);
    chk("rst_sat", int'(sat0), 0);
    chk("rst_ch", int'(och0), 0);
    chk("rst_vld_d1", int'(ov1), 0);
    rstn = 1'b1;
    tick();

    cin0 = pack4(1, 2, 3, 4); cld0 = 1'b1;
    cin1 = pack4(1, 0, 0, 0); cld1 = 1'b1;
    tick();
    cld0 = 1'b0; cld1 = 1'b0;

    // Symmetric impulse.
    for (int j = 0; j < 7; j++) send0(1'b0, (j == 0) ? 1 : 0, 1'b0, 1'b1, sym[j]);
    idle(8);
    clr0 = 1'b1; tick(); clr0 = 1'b0;

    // Antisymmetric impulse.
    for (int j = 0; j < 7; j++) send0(1'b0, (j == 0) ? 1 : 0, 1'b1, 1'b1, asy[j]);
    idle(8);
    clr0 = 1'b1; tick(); clr0 = 1'b0;

    // Back-to-back channel interleave.
    for (int j = 0; j < 7; j++) begin
      send0(1'b0, (j == 0) ? 1 : 0, 1'b0, 1'b1, sym[j]);
      send0(1'b1, 0, 1'b0, 1'b1, 0);
    end
    idle(8);

    // Clear together with a coefficient load: both take effect.
    clr0 = 1'b1; cld0 = 1'b1; cin0 = pack4(1, 1, 1, 1);
    tick();
    clr0 = 1'b0; cld0 = 1'b0;

    // Saturation with continuous 511.
    for (int j = 0; j < 10; j++) send0(1'b0, 511, 1'b0, 1'b1, 511);
    idle(8);
    chk("sat_set", int'(sat0), 1);

    // Clear mid-stream with a valid sample: nothing in flight may emerge.
    for (int j = 0; j < 4; j++) send0(1'b0, 511, 1'b0, 1'b0, 0);
    chk("sat_hold", int'(sat0), 1);
    dv0 = 1'b1; din0 = 10'sd511; clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_vld", int'(ov0), 0);
    chk("clr_sat", int'(sat0), 0);
    idle(8);
    chk("clr_sat_after", int'(sat0), 0);

    // Coefficient switch during a step input.
    clr0 = 1'b1; cld0 = 1'b1; cin0 = pack4(1, 2, 3, 4);
    tick();
    clr0 = 1'b0; cld0 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j == 4) begin
        cld0 = 1'b1; cin0 = pack4(0, 0, 0, 1);
      end else begin
        cld0 = 1'b0;
      end
      send0(1'b0, 1, 1'b0, 1'b1, stp[j]);
    end
    cld0 = 1'b0;
    idle(8);

    // Rounding on the SL=2 instance.
    for (int j = 0; j < 6; j++) send1(rin[j], rout[j]);
    idle(8);

    // Asynchronous reset mid-stream: in-flight samples vanish, bank zeroed.
    for (int j = 0; j < 3; j++) send0(1'b0, 300, 1'b0, 1'b0, 0);
    rstn = 1'b0;
    #2;
    chk("arst_vld", int'(ov0), 0);
    chk("arst_dout", int'(dout0), 0);
    dv0 = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    send0(1'b0, 100, 1'b0, 1'b1, 0);
    idle(8);

    // Bounded drain, then every queued expectation must have been consumed.
    for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) tick();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
